screen_buffer_arbiter: RTL and testbench

SCREEN_BUFFER_ARBITER -- requirements
Module: screen_buffer_arbiter

---
 rtl/screen_buffer_arbiter.sv | 121 ++++++++++++
 tb/tb_screen_buffer_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_buffer_arbiter.sv
// Screen-buffer port arbiter: display reads own the buffer while visible; queued writer
// pixels drain one per cycle during blanking.
module screen_buffer_arbiter #(
  parameter int unsigned ADDR_BITS  = 14,
  parameter int unsigned DATA_BITS  = 6,
  parameter int unsigned MEM_WORDS  = 10000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          display_active,
  input  logic [ADDR_BITS-1:0]          rd_addr,
  output logic [DATA_BITS-1:0]          rd_data,
  input  logic                          wr_valid,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic [ADDR_BITS-1:0]          mem_addr,
  output logic                          mem_we,
  output logic [DATA_BITS-1:0]          mem_wdata,
  input  logic [DATA_BITS-1:0]          mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count,
  output logic                          err_oob,
  input  logic                          err_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   LP_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] LP_WORDS = (ADDR_BITS + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e               r_state, w_state_d;
  logic                 r_disp_q;
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count, w_count_d;
  logic                 r_err;
  logic [ADDR_BITS-1:0] r_q_addr [FIFO_DEPTH];
  logic [DATA_BITS-1:0] r_q_data [FIFO_DEPTH];

  logic w_ready, w_accept, w_in_range, w_push, w_drop, w_pop;

  assign w_ready    = (r_count < LP_DEPTH);
  assign w_accept   = wr_valid & w_ready;
  assign w_in_range = ({1'b0, wr_addr} < LP_WORDS);
  assign w_push     = w_accept & w_in_range;
  assign w_drop     = w_accept & ~w_in_range;
  // DRAIN already implies a non-empty queue and blanking; the extra term is a safety guard.
  assign w_pop      = (r_state == StDrain) & ~r_disp_q & (r_count != '0);

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CNT_W'(1);
    end
  end

  // The state register always holds the decode of display_active_q and queue_count
  // as they stand after the same edge, so a rise stops draining after one more write.
  always_comb begin
    w_state_d = StIdle;
    if (display_active) begin
      w_state_d = StRead;
    end else if (w_count_d != '0) begin
      w_state_d = StDrain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_disp_q <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_disp_q <= display_active;
      r_count  <= w_count_d;
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= wr_addr;
      r_q_data[r_wptr] <= wr_data;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = rd_addr;
    mem_wdata = '0;
    if (w_pop) begin
      mem_we    = 1'b1;
      mem_addr  = r_q_addr[r_rptr];
      mem_wdata = r_q_data[r_rptr];
    end
  end

  assign rd_data     = mem_rdata;
  assign wr_ready    = w_ready;
  assign queue_count = r_count;
  assign err_oob     = r_err;

endmodule

// File: tb/tb_screen_buffer_arbiter.sv
// Randomised scoreboard bench for screen_buffer_arbiter with a behavioural buffer memory.
module tb_screen_buffer_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 6;
  localparam int unsigned MW    = 10000;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          display_active = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    queue_count;
  logic          err_oob;
  logic          err_clr = 1'b0;

  screen_buffer_arbiter #(
    .ADDR_BITS (AW),
    .DATA_BITS (DW),
    .MEM_WORDS (MW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_active(display_active),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .queue_count   (queue_count),
    .err_oob       (err_oob),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural screen buffer with a registered one-cycle read.
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: accepted in-range writes form an ordered list; while blanking was seen on the
  // previous cycle, the oldest pending write is due in the current cycle.
  logic [AW+DW-1:0] q_exp [$];
  logic             m_err = 1'b0;
  logic             da_prev = 1'b0;

  always @(negedge clk) begin
    int unsigned      sz;
    logic             exp_we;
    logic [AW+DW-1:0] head;
    if (!rst_n) begin
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_count", queue_count, 0);
      chk("rst_mem_addr", mem_addr, rd_addr);
      chk("rst_err", err_oob, 0);
      q_exp.delete();
      m_err   = 1'b0;
      da_prev = 1'b0;
    end else begin
      sz     = q_exp.size();
      exp_we = !da_prev && (sz > 0);
      chk("queue_count", queue_count, sz);
      chk("wr_ready", wr_ready, (sz < DEPTH));
      chk("mem_we", mem_we, exp_we);
      chk("err_oob", err_oob, m_err);
      chk("rd_data", rd_data, mem_rdata);
      if (exp_we) begin
        head = q_exp.pop_front();
        chk("wr_addr_order", mem_addr, head[AW+DW-1:DW]);
        chk("wr_data_order", mem_wdata, head[DW-1:0]);
      end else begin
        chk("mem_addr_pass", mem_addr, rd_addr);
        chk("mem_wdata_zero", mem_wdata, 0);
      end
      if (wr_valid && sz < DEPTH) begin
        if (wr_addr < MW) q_exp.push_back({wr_addr, wr_data});
        else m_err = 1'b1;
      end
      if (!(wr_valid && sz < DEPTH && wr_addr >= MW) && err_clr) m_err = 1'b0;
      da_prev = display_active;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (queue_count == 0) break;
    end
    chk(nm, queue_count, 0);
    cyc();
  endtask

  initial begin
    bit          took;
    int unsigned run, r;
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = DW'($urandom);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Read passthrough and one-cycle read data.
    display_active = 1'b1;
    rd_addr = 14'h0123;
    cyc();
    @(negedge clk);
    chk("mem_addr_0123", mem_addr, 14'h0123);
    chk("rd_pixel_0123", rd_data, tb_mem[14'h0123]);
    cyc();

    // Fill the queue while visible, then stall a fifth write across blanking.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(10 + i);
      wr_data  = DW'(i + 1);
      cyc();
    end
    wr_addr = 14'd20;
    wr_data = 6'h2a;
    cyc();
    cyc();
    @(negedge clk);
    chk("full_count", queue_count, 4);
    chk("full_ready", wr_ready, 0);
    cyc();
    display_active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    chk("stall_release", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    wait_empty("drain_full");

    // Out-of-range write is dropped and flagged; err_clr clears the flag.
    display_active = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 14'(MW);
    cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("oob_flag", err_oob, 1);
    chk("oob_count", queue_count, 0);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("oob_cleared", err_oob, 0);
    cyc();

    // Push while draining keeps ordering.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(30 + i);
      wr_data  = DW'(7 + i);
      cyc();
    end
    display_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(40 + i);
      wr_data = DW'(20 + i);
      cyc();
    end
    wr_valid = 1'b0;
    wait_empty("drain_mixed");

    // Reset mid-drain with three entries queued.
    display_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(50 + i);
      wr_data  = DW'(i);
      cyc();
    end
    wr_valid = 1'b0;
    display_active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (queue_count == 3) break;
    end
    chk("pre_reset_count", queue_count, 3);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("reset_we_now", mem_we, 0);
    chk("reset_count_now", queue_count, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    cyc();

    // Randomised traffic with a writer that holds its offer until taken.
    run = 5;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = wr_valid && wr_ready;
      cyc();
      if (run == 0) begin
        display_active = !display_active;
        run = display_active ? $urandom_range(4, 24) : $urandom_range(1, 12);
      end else begin
        run--;
      end
      rd_addr = AW'($urandom_range(0, MW - 1));
      if (!wr_valid || took) begin
        wr_valid = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 15);
        if (r == 0) wr_addr = AW'(MW + $urandom_range(0, 3));
        else if (r == 1) wr_addr = 14'h3fff;
        else wr_addr = AW'($urandom_range(0, MW - 1));
        wr_data = DW'($urandom);
      end
      err_clr = ($urandom_range(0, 9) == 0);
    end
    wr_valid = 1'b0;
    err_clr = 1'b0;
    display_active = 1'b0;
    wait_empty("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
